// File: rtl/ploc_occupancy_tracker_pkg.sv
// Types shared by the parking-lot sensor FSM and the occupancy tracker.
// Purely declarative: no latency and no flow control.
package ploc_pkg;

  // State encoding of the upstream two-beam sensor FSM.
  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_A_BLOCKED = 3'd1,
    ST_AB_IN     = 3'd2,
    ST_B_BLOCKED = 3'd3,
    ST_AB_OUT    = 3'd4
  } t_ploc_state;

  localparam int MAX_CARS_DEFAULT = 99;

  typedef logic [3:0] t_bcd_digit;

endpackage

// File: rtl/ploc_occupancy_tracker_bcd.sv
// One BCD up/down digit. The digit register updates on the clock edge; carry and borrow are combinational.
// No flow control: every inc or dec is applied in the cycle it is seen.
module bcd_updown_digit
  import ploc_pkg::*;
(
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_inc,
  input  logic       i_dec,
  output t_bcd_digit o_digit,
  output logic       o_carry,
  output logic       o_borrow
);

  t_bcd_digit digit_q, digit_d;

  always_comb begin
    digit_d = digit_q;
    if (i_inc) begin
      digit_d = (digit_q == 4'd9) ? 4'd0 : digit_q + 4'd1;
    end else if (i_dec) begin
      digit_d = (digit_q == 4'd0) ? 4'd9 : digit_q - 4'd1;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) digit_q <= 4'd0;
    else       digit_q <= digit_d;
  end

  assign o_digit  = digit_q;
  assign o_carry  = i_inc && (digit_q == 4'd9);
  assign o_borrow = i_dec && (digit_q == 4'd0);

endmodule

// File: rtl/ploc_occupancy_tracker.sv
// Parking-lot occupancy counter (binary + BCD) with status flags; PLOC_STICKY_ERR_EN makes the error flags sticky.
// A pulse is captured at edge k and the count, flags and errors update at edge k+1. No backpressure: one event per cycle.
module ploc_occupancy_tracker
  import ploc_pkg::*;
#(
  parameter int MAX_CARS         = MAX_CARS_DEFAULT,
  parameter int NEAR_FULL_MARGIN = 5
) (
  input  logic                          i_clk,
  input  logic                          i_rst,
  input  logic                          i_car_enter,
  input  logic                          i_car_exit,
  input  logic                          i_clr_err,
  output logic [$clog2(MAX_CARS+1)-1:0] o_count,
  output t_bcd_digit                    o_bcd_tens,
  output t_bcd_digit                    o_bcd_ones,
  output logic                          o_empty,
  output logic                          o_near_full,
  output logic                          o_full,
  output logic                          o_err_overflow,
  output logic                          o_err_underflow
);

  localparam int            CW    = $clog2(MAX_CARS + 1);
  localparam logic [CW-1:0] MAX_C = CW'(MAX_CARS);
  localparam logic [CW-1:0] NF_C  = CW'(MAX_CARS - NEAR_FULL_MARGIN);

  logic          enter_q, exit_q;
  logic [CW-1:0] count_q, count_d;
  logic          inc, dec, ovf_evt, unf_evt;
  logic          ovf_q, ovf_d, unf_q, unf_d;
  logic          ones_carry, ones_borrow;
  logic          tens_carry_unused, tens_borrow_unused;

  // Simultaneous enter and exit nets to zero and never raises an error.
  always_comb begin
    inc     = 1'b0;
    dec     = 1'b0;
    ovf_evt = 1'b0;
    unf_evt = 1'b0;
    case ({enter_q, exit_q})
      2'b10: begin
        if (count_q == MAX_C) ovf_evt = 1'b1;
        else                  inc     = 1'b1;
      end
      2'b01: begin
        if (count_q == '0) unf_evt = 1'b1;
        else               dec     = 1'b1;
      end
      default: ;
    endcase

    count_d = count_q;
    if (inc)      count_d = count_q + CW'(1);
    else if (dec) count_d = count_q - CW'(1);
  end

`ifdef PLOC_STICKY_ERR_EN
  // A new error outranks a clear on the same edge.
  assign ovf_d = ovf_evt | (ovf_q & ~i_clr_err);
  assign unf_d = unf_evt | (unf_q & ~i_clr_err);
`else
  logic clr_err_unused;
  assign clr_err_unused = i_clr_err;
  assign ovf_d = ovf_evt;
  assign unf_d = unf_evt;
`endif

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      enter_q <= 1'b0;
      exit_q  <= 1'b0;
      count_q <= '0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      enter_q <= i_car_enter;
      exit_q  <= i_car_exit;
      count_q <= count_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
    end
  end

  bcd_updown_digit u_ones (
    .i_clk    (i_clk),
    .i_rst    (i_rst),
    .i_inc    (inc),
    .i_dec    (dec),
    .o_digit  (o_bcd_ones),
    .o_carry  (ones_carry),
    .o_borrow (ones_borrow)
  );

  // Saturation is enforced upstream of the ones digit, so the tens digit never wraps.
  bcd_updown_digit u_tens (
    .i_clk    (i_clk),
    .i_rst    (i_rst),
    .i_inc    (ones_carry),
    .i_dec    (ones_borrow),
    .o_digit  (o_bcd_tens),
    .o_carry  (tens_carry_unused),
    .o_borrow (tens_borrow_unused)
  );

  assign o_count         = count_q;
  assign o_empty         = (count_q == '0);
  assign o_full          = (count_q == MAX_C);
  assign o_near_full     = (count_q >= NF_C);
  assign o_err_overflow  = ovf_q;
  assign o_err_underflow = unf_q;

endmodule

// File: tb/tb_ploc_occupancy_tracker.sv
// Bench for ploc_occupancy_tracker: directed scenarios plus random traffic against an arithmetic occupancy model.
// Build with or without PLOC_STICKY_ERR_EN; the model follows the same macro.
module tb_ploc_occupancy_tracker;

  localparam int MAX    = 99;
  localparam int MARGIN = 5;

  logic       i_clk = 1'b0;
  logic       i_rst = 1'b0;
  logic       i_car_enter = 1'b0;
  logic       i_car_exit = 1'b0;
  logic       i_clr_err = 1'b0;
  logic [6:0] o_count;
  logic [3:0] o_bcd_tens, o_bcd_ones;
  logic       o_empty, o_near_full, o_full, o_err_overflow, o_err_underflow;

  int tests = 0;
  int fails = 0;

  // Reference model: occupancy as an integer plus the one pulse in flight.
  int m_count = 0;
  bit m_ovf = 1'b0;
  bit m_unf = 1'b0;
  bit pend_e = 1'b0;
  bit pend_x = 1'b0;

  ploc_occupancy_tracker #(.MAX_CARS(MAX), .NEAR_FULL_MARGIN(MARGIN)) dut (
    .i_clk           (i_clk),
    .i_rst           (i_rst),
    .i_car_enter     (i_car_enter),
    .i_car_exit      (i_car_exit),
    .i_clr_err       (i_clr_err),
    .o_count         (o_count),
    .o_bcd_tens      (o_bcd_tens),
    .o_bcd_ones      (o_bcd_ones),
    .o_empty         (o_empty),
    .o_near_full     (o_near_full),
    .o_full          (o_full),
    .o_err_overflow  (o_err_overflow),
    .o_err_underflow (o_err_underflow)
  );

  always #5 i_clk = ~i_clk;

  task automatic model_reset();
    m_count = 0;
    m_ovf   = 1'b0;
    m_unf   = 1'b0;
    pend_e  = 1'b0;
    pend_x  = 1'b0;
  endtask

  // Drive one cycle of inputs, advance the model on the edge, return 1 time unit after it.
  task automatic cycle(input bit ce, input bit cx, input bit cc);
    bit ov;
    bit un;
    ov = 1'b0;
    un = 1'b0;
    i_car_enter = ce;
    i_car_exit  = cx;
    i_clr_err   = cc;
    @(posedge i_clk);
    if (pend_e && !pend_x) begin
      if (m_count < MAX) m_count++;
      else               ov = 1'b1;
    end else if (!pend_e && pend_x) begin
      if (m_count > 0) m_count--;
      else             un = 1'b1;
    end
`ifdef PLOC_STICKY_ERR_EN
    m_ovf = ov | (m_ovf & !cc);
    m_unf = un | (m_unf & !cc);
`else
    m_ovf = ov;
    m_unf = un;
`endif
    pend_e = ce;
    pend_x = cx;
    #1;
    i_car_enter = 1'b0;
    i_car_exit  = 1'b0;
    i_clr_err   = 1'b0;
  endtask

  task automatic set_count(input int target);
    int n;
    n = target - m_count;
    if (n > 0) repeat (n) cycle(1'b1, 1'b0, 1'b0);
    else if (n < 0) repeat (-n) cycle(1'b0, 1'b1, 1'b0);
    cycle(1'b0, 1'b0, 1'b0);
  endtask

  task automatic apply_reset();
    @(negedge i_clk);
    i_rst = 1'b1;
    model_reset();
    @(negedge i_clk);
    i_rst = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    apply_reset();
    tests++;
    if (o_count !== 7'd0 || o_bcd_tens !== 4'd0 || o_bcd_ones !== 4'd0 || o_empty !== 1'b1 ||
        o_full !== 1'b0 || o_near_full !== 1'b0 || o_err_overflow !== 1'b0 || o_err_underflow !== 1'b0) begin
      fails++;
      $display("FAIL reset: count=%0d bcd=%0d/%0d empty=%b full=%b nf=%b ovf=%b unf=%b, want 0 0/0 1 0 0 0 0",
               o_count, o_bcd_tens, o_bcd_ones, o_empty, o_full, o_near_full, o_err_overflow, o_err_underflow);
    end
  endtask

  task automatic test_basic_count();
    apply_reset();
    repeat (3) cycle(1'b1, 1'b0, 1'b0);
    tests++;
    if (o_count !== 7'd2) begin
      fails++;
      $display("FAIL basic_latency: count=%0d after third pulse edge, want 2", o_count);
    end
    cycle(1'b0, 1'b0, 1'b0);
    tests++;
    if (o_count !== 7'd3 || o_bcd_tens !== 4'd0 || o_bcd_ones !== 4'd3 || o_empty !== 1'b0) begin
      fails++;
      $display("FAIL basic_count: count=%0d bcd=%0d/%0d empty=%b, want 3 0/3 0",
               o_count, o_bcd_tens, o_bcd_ones, o_empty);
    end
  endtask

  task automatic test_bcd_carry_borrow();
    apply_reset();
    set_count(9);
    tests++;
    if (o_count !== 7'd9 || o_bcd_tens !== 4'd0 || o_bcd_ones !== 4'd9) begin
      fails++;
      $display("FAIL bcd_nine: count=%0d bcd=%0d/%0d, want 9 0/9", o_count, o_bcd_tens, o_bcd_ones);
    end
    set_count(10);
    tests++;
    if (o_count !== 7'd10 || o_bcd_tens !== 4'd1 || o_bcd_ones !== 4'd0) begin
      fails++;
      $display("FAIL bcd_carry: count=%0d bcd=%0d/%0d, want 10 1/0", o_count, o_bcd_tens, o_bcd_ones);
    end
    set_count(9);
    tests++;
    if (o_count !== 7'd9 || o_bcd_tens !== 4'd0 || o_bcd_ones !== 4'd9) begin
      fails++;
      $display("FAIL bcd_borrow: count=%0d bcd=%0d/%0d, want 9 0/9", o_count, o_bcd_tens, o_bcd_ones);
    end
  endtask

  task automatic test_fill_overflow();
    apply_reset();
    set_count(93);
    tests++;
    if (o_near_full !== 1'b0) begin
      fails++;
      $display("FAIL near_full_93: near_full=%b, want 0", o_near_full);
    end
    set_count(94);
    tests++;
    if (o_near_full !== 1'b1 || o_full !== 1'b0) begin
      fails++;
      $display("FAIL near_full_94: near_full=%b full=%b, want 1 0", o_near_full, o_full);
    end
    set_count(99);
    tests++;
    if (o_count !== 7'd99 || o_full !== 1'b1 || o_near_full !== 1'b1 || o_bcd_tens !== 4'd9 || o_bcd_ones !== 4'd9) begin
      fails++;
      $display("FAIL full: count=%0d full=%b nf=%b bcd=%0d/%0d, want 99 1 1 9/9",
               o_count, o_full, o_near_full, o_bcd_tens, o_bcd_ones);
    end
    cycle(1'b1, 1'b0, 1'b0);
    tests++;
    if (o_err_overflow !== 1'b0) begin
      fails++;
      $display("FAIL overflow_early: ovf=%b one edge after pulse, want 0", o_err_overflow);
    end
    cycle(1'b0, 1'b0, 1'b0);
    tests++;
    if (o_count !== 7'd99 || o_err_overflow !== 1'b1) begin
      fails++;
      $display("FAIL overflow: count=%0d ovf=%b, want 99 1", o_count, o_err_overflow);
    end
    cycle(1'b0, 1'b0, 1'b0);
    tests++;
`ifdef PLOC_STICKY_ERR_EN
    if (o_err_overflow !== 1'b1) begin
      fails++;
      $display("FAIL overflow_hold: ovf=%b, want 1 (sticky)", o_err_overflow);
    end
`else
    if (o_err_overflow !== 1'b0) begin
      fails++;
      $display("FAIL overflow_pulse: ovf=%b, want 0 (single cycle)", o_err_overflow);
    end
`endif
    cycle(1'b0, 1'b0, 1'b1);
    tests++;
    if (o_err_overflow !== 1'b0 || o_count !== 7'd99) begin
      fails++;
      $display("FAIL overflow_clear: ovf=%b count=%0d, want 0 99", o_err_overflow, o_count);
    end
  endtask

  task automatic test_underflow_simultaneous();
    apply_reset();
    cycle(1'b0, 1'b1, 1'b0);
    cycle(1'b0, 1'b0, 1'b0);
    tests++;
    if (o_count !== 7'd0 || o_err_underflow !== 1'b1 || o_empty !== 1'b1) begin
      fails++;
      $display("FAIL underflow: count=%0d unf=%b empty=%b, want 0 1 1", o_count, o_err_underflow, o_empty);
    end
    apply_reset();
    set_count(50);
    cycle(1'b1, 1'b1, 1'b0);
    cycle(1'b0, 1'b0, 1'b0);
    tests++;
    if (o_count !== 7'd50 || o_err_overflow !== 1'b0 || o_err_underflow !== 1'b0) begin
      fails++;
      $display("FAIL simul_50: count=%0d ovf=%b unf=%b, want 50 0 0", o_count, o_err_overflow, o_err_underflow);
    end
    set_count(99);
    cycle(1'b1, 1'b1, 1'b0);
    cycle(1'b0, 1'b0, 1'b0);
    tests++;
    if (o_count !== 7'd99 || o_err_overflow !== 1'b0) begin
      fails++;
      $display("FAIL simul_99: count=%0d ovf=%b, want 99 0", o_count, o_err_overflow);
    end
  endtask

  task automatic test_mid_reset();
    apply_reset();
    set_count(42);
    tests++;
    if (o_count !== 7'd42 || o_bcd_tens !== 4'd4 || o_bcd_ones !== 4'd2) begin
      fails++;
      $display("FAIL pre_reset: count=%0d bcd=%0d/%0d, want 42 4/2", o_count, o_bcd_tens, o_bcd_ones);
    end
    cycle(1'b1, 1'b0, 1'b0);
    #2;
    i_rst = 1'b1;
    #1;
    tests++;
    if (o_count !== 7'd0 || o_bcd_tens !== 4'd0 || o_bcd_ones !== 4'd0 || o_empty !== 1'b1) begin
      fails++;
      $display("FAIL async_reset: count=%0d bcd=%0d/%0d empty=%b before next edge, want 0 0/0 1",
               o_count, o_bcd_tens, o_bcd_ones, o_empty);
    end
    #1;
    i_rst = 1'b0;
    model_reset();
    cycle(1'b0, 1'b0, 1'b0);
    cycle(1'b0, 1'b0, 1'b0);
    tests++;
    if (o_count !== 7'd0 || o_empty !== 1'b1) begin
      fails++;
      $display("FAIL pulse_lost: count=%0d empty=%b, want 0 1", o_count, o_empty);
    end
  endtask

  task automatic test_random();
    bit ce, cx, cc;
    int r;
    apply_reset();
    for (int i = 0; i < 2000; i++) begin
      r = $urandom_range(0, 99);
      if (((i / 400) % 2) == 0) begin
        ce = (r < 70);
        cx = (r >= 60 && r < 80);
      end else begin
        ce = (r < 20);
        cx = (r >= 10 && r < 80);
      end
      cc = ($urandom_range(0, 7) == 0);
      cycle(ce, cx, cc);
      tests++;
      if (o_count !== 7'(m_count) || o_bcd_tens !== 4'(m_count / 10) || o_bcd_ones !== 4'(m_count % 10) ||
          o_empty !== (m_count == 0) || o_full !== (m_count == MAX) || o_near_full !== (m_count >= MAX - MARGIN) ||
          o_err_overflow !== m_ovf || o_err_underflow !== m_unf) begin
        fails++;
        $display("FAIL random[%0d]: count=%0d bcd=%0d/%0d e=%b nf=%b f=%b ovf=%b unf=%b, want count=%0d ovf=%b unf=%b",
                 i, o_count, o_bcd_tens, o_bcd_ones, o_empty, o_near_full, o_full,
                 o_err_overflow, o_err_underflow, m_count, m_ovf, m_unf);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic_count();
    test_bcd_carry_borrow();
    test_fill_overflow();
    test_underflow_simultaneous();
    test_mid_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
